// File: rtl/ifu_pkg.sv
// Shared types and default parameters for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } ifu_state_e;

    localparam int          DEF_AWIDTH    = 6;
    localparam int          DEF_RWIDTH    = 32;
    localparam int          DEF_RESET_PC  = 0;
    localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/ifu_imem.sv
// Instruction RAM: one write port and one read-first registered read port.
// A second, combinational peek at the read address exposes the word that the next edge will latch.
module ifu_imem #(
    parameter int AWIDTH = 6,
    parameter int RWIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_waddr,
    input  logic [RWIDTH-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AWIDTH-1:0] i_raddr,
    output logic [RWIDTH-1:0] o_rdata,
    output logic [RWIDTH-1:0] o_peek
);

    logic [RWIDTH-1:0] r_mem [2**AWIDTH];
    logic [RWIDTH-1:0] r_rdata;

    // Contents are never cleared; writes also proceed while reset is held.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst)    r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
    assign o_peek  = r_mem[i_raddr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: PC sequencing, IDLE/RUN/HALTED control and redirect handling around ifu_imem.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                AWIDTH    = DEF_AWIDTH,
    parameter int                RWIDTH    = DEF_RWIDTH,
    parameter logic [AWIDTH-1:0] RESET_PC  = AWIDTH'(DEF_RESET_PC),
    parameter logic [RWIDTH-1:0] HALT_WORD = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_addr,
    input  logic              imem_we,
    input  logic [AWIDTH-1:0] imem_waddr,
    input  logic [RWIDTH-1:0] imem_wdata,
    output logic [AWIDTH-1:0] pc,
    output logic [RWIDTH-1:0] instr,
    output logic [AWIDTH-1:0] instr_pc,
    output logic              instr_valid,
    output logic              halted
);

    ifu_state_e        r_state, w_state_nxt;
    logic [AWIDTH-1:0] r_pc, w_pc_nxt;
    logic [AWIDTH-1:0] r_instr_pc, w_instr_pc_nxt;
    logic              r_instr_valid, w_instr_valid_nxt;
    logic              w_fetch;
    logic [RWIDTH-1:0] w_word;

    ifu_imem #(.AWIDTH(AWIDTH), .RWIDTH(RWIDTH)) u_imem (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (imem_we),
        .i_waddr (imem_waddr),
        .i_wdata (imem_wdata),
        .i_re    (w_fetch),
        .i_raddr (r_pc),
        .o_rdata (instr),
        .o_peek  (w_word)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Redirect outranks stall, run and halt detection; stall freezes everything else.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_pc_nxt    = r_instr_pc;
        w_instr_valid_nxt = r_instr_valid;
        w_fetch           = 1'b0;
        if (redirect_valid) begin
            w_pc_nxt          = redirect_addr;
            w_instr_valid_nxt = 1'b0;
            if (r_state == S_HALTED) w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_instr_valid_nxt = 1'b0;
                    if (run) w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (!stall) begin
                        if (!run) begin
                            w_state_nxt       = S_IDLE;
                            w_instr_valid_nxt = 1'b0;
                        end else begin
                            w_fetch           = 1'b1;
                            w_instr_pc_nxt    = r_pc;
                            w_instr_valid_nxt = 1'b1;
                            if (w_word == HALT_WORD) w_state_nxt = S_HALTED;
                            else                     w_pc_nxt    = r_pc + 1'b1;
                        end
                    end
                end
                S_HALTED: begin
                    if (!stall) w_instr_valid_nxt = 1'b0;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_valid <= w_instr_valid_nxt;
        end
    end

    assign pc          = r_pc;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign halted      = (r_state == S_HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; a second instance covers PC wrap from RESET_PC=63.
module tb_instruction_fetch_unit;

    localparam int AW = 6;
    localparam int RW = 32;
    localparam logic [RW-1:0] HALT = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          run = 1'b0;
    logic          stall = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          imem_we = 1'b0;
    logic [AW-1:0] imem_waddr = '0;
    logic [RW-1:0] imem_wdata = '0;
    logic [AW-1:0] pc, instr_pc;
    logic [RW-1:0] instr;
    logic          instr_valid, halted;

    logic          run2 = 1'b0;
    logic          stall2 = 1'b0;
    logic          redir2 = 1'b0;
    logic [AW-1:0] redir2_addr = '0;
    logic [AW-1:0] pc2, instr_pc2;
    logic [RW-1:0] instr2;
    logic          instr_valid2, halted2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.AWIDTH(AW), .RWIDTH(RW)) dut (
        .clk(clk), .rst(rst), .run(run), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc(pc), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .halted(halted)
    );

    instruction_fetch_unit #(.AWIDTH(AW), .RWIDTH(RW), .RESET_PC(6'd63)) dut_wrap (
        .clk(clk), .rst(rst), .run(run2), .stall(stall2),
        .redirect_valid(redir2), .redirect_addr(redir2_addr),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .pc(pc2), .instr(instr2), .instr_pc(instr_pc2),
        .instr_valid(instr_valid2), .halted(halted2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [RW-1:0] d);
        imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
        tick();
        imem_we = 1'b0;
    endtask

    task automatic fetch_chk(input string tag, input logic [RW-1:0] ei, input logic [AW-1:0] ep,
                             input logic [AW-1:0] enext);
        chk({tag, "_instr"}, 64'(instr), 64'(ei));
        chk({tag, "_ipc"},   64'(instr_pc), 64'(ep));
        chk({tag, "_vld"},   64'(instr_valid), 64'd1);
        chk({tag, "_pc"},    64'(pc), 64'(enext));
    endtask

    initial begin
        tick(); tick();
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_ipc", 64'(instr_pc), 64'd0);
        chk("rst_vld", 64'(instr_valid), 64'd0);
        chk("rst_halt", 64'(halted), 64'd0);
        chk("rst_pc2", 64'(pc2), 64'd63);

        // program load while reset is still held
        wr(6'd0, 32'h11); wr(6'd1, 32'h22); wr(6'd2, 32'h33); wr(6'd3, HALT);
        wr(6'd4, 32'h44); wr(6'd5, 32'h55); wr(6'd6, 32'h66);
        wr(6'h20, 32'hC0DE); wr(6'h21, 32'hBEEF); wr(6'd63, 32'h3F3F);
        chk("rst_hold_vld", 64'(instr_valid), 64'd0);

        rst = 1'b1; run = 1'b1; run2 = 1'b1;
        tick();
        chk("idle2run_vld", 64'(instr_valid), 64'd0);
        chk("idle2run_pc", 64'(pc), 64'd0);
        tick();
        fetch_chk("f0", 32'h11, 6'd0, 6'd1);
        chk("wrap_instr63", 64'(instr2), 64'h3F3F);
        chk("wrap_ipc63", 64'(instr_pc2), 64'd63);
        chk("wrap_pc0", 64'(pc2), 64'd0);
        tick();
        run2 = 1'b0;
        fetch_chk("f1", 32'h22, 6'd1, 6'd2);
        chk("wrap_ipc0", 64'(instr_pc2), 64'd0);
        chk("wrap_instr0", 64'(instr2), 64'h11);
        tick();
        fetch_chk("f2", 32'h33, 6'd2, 6'd3);
        tick();
        fetch_chk("fhalt", HALT, 6'd3, 6'd3);
        chk("fhalt_halted", 64'(halted), 64'd1);
        tick();
        chk("halted_vld", 64'(instr_valid), 64'd0);
        chk("halted_pc", 64'(pc), 64'd3);
        chk("halted_flag", 64'(halted), 64'd1);
        tick();
        chk("halted_stays", 64'(halted), 64'd1);

        // leave HALTED by redirect to 4, then fetch 4 and stall at pc=5
        redirect_valid = 1'b1; redirect_addr = 6'd4;
        tick();
        redirect_valid = 1'b0;
        chk("unhalt_pc", 64'(pc), 64'd4);
        chk("unhalt_vld", 64'(instr_valid), 64'd0);
        chk("unhalt_halted", 64'(halted), 64'd0);
        tick();
        fetch_chk("f4", 32'h44, 6'd4, 6'd5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            fetch_chk($sformatf("stall%0d", i), 32'h44, 6'd4, 6'd5);
        end
        stall = 1'b0;
        tick();
        fetch_chk("resume5", 32'h55, 6'd5, 6'd6);

        // redirect beats stall
        stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 6'h20;
        tick();
        stall = 1'b0; redirect_valid = 1'b0;
        chk("rdst_pc", 64'(pc), 64'h20);
        chk("rdst_vld", 64'(instr_valid), 64'd0);
        tick();
        fetch_chk("rdst_f", 32'hC0DE, 6'h20, 6'h21);

        // same-cycle write and fetch of address 4 returns old data
        redirect_valid = 1'b1; redirect_addr = 6'd4;
        tick();
        redirect_valid = 1'b0;
        imem_we = 1'b1; imem_waddr = 6'd4; imem_wdata = 32'hAA;
        tick();
        imem_we = 1'b0;
        fetch_chk("rf_old", 32'h44, 6'd4, 6'd5);
        redirect_valid = 1'b1; redirect_addr = 6'd4;
        tick();
        redirect_valid = 1'b0;
        tick();
        fetch_chk("rf_new", 32'hAA, 6'd4, 6'd5);

        // run=0 returns to IDLE without advancing pc
        run = 1'b0;
        tick();
        chk("stop_vld", 64'(instr_valid), 64'd0);
        chk("stop_pc", 64'(pc), 64'd5);
        tick();
        chk("idle_pc", 64'(pc), 64'd5);
        run = 1'b1;
        tick();
        chk("restart_vld", 64'(instr_valid), 64'd0);
        tick();
        fetch_chk("restart_f", 32'h55, 6'd5, 6'd6);

        // reset with redirect pending; memory must survive
        rst = 1'b0; redirect_valid = 1'b1; redirect_addr = 6'h21;
        tick();
        redirect_valid = 1'b0;
        chk("mrst_pc", 64'(pc), 64'd0);
        chk("mrst_vld", 64'(instr_valid), 64'd0);
        chk("mrst_halt", 64'(halted), 64'd0);
        chk("mrst_instr", 64'(instr), 64'd0);
        rst = 1'b1;
        tick();
        chk("mrst_idle_vld", 64'(instr_valid), 64'd0);
        tick();
        fetch_chk("mrst_f0", 32'h11, 6'd0, 6'd1);
        redirect_valid = 1'b1; redirect_addr = 6'd4;
        tick();
        redirect_valid = 1'b0;
        tick();
        fetch_chk("mrst_mem4", 32'hAA, 6'd4, 6'd5);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
